// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared types and constants for the instruction-memory boot sequencer
package imem_boot_pkg;
    localparam int IMEM_DATA_W = 32;
    localparam logic [IMEM_DATA_W-1:0] NOP_WORD = 32'h0;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_PAD,
        S_RUN,
        S_DONE,
        S_ERROR
    } boot_state_e;
endpackage

// File: rtl/boot_run_timer.sv
// boot_run_timer: loadable run-budget down-counter; a zero budget never expires
module boot_run_timer #(
    parameter int RUN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RUN_W-1:0] budget,
    input  logic             en,
    output logic             expire
);
    logic [RUN_W-1:0] cnt_q, cnt_d;
    // Expire fires during the last budgeted cycle so the caller leaves after exactly budget cycles
    assign expire = en && cnt_q == RUN_W'(1);
    // Reload on a new sequence, otherwise count down while running and park at zero
    always_comb begin
        cnt_d = load ? budget : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer: clears imem, streams a program in, pads with NOPs, then runs the core for a budget
module imem_boot_sequencer
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int PAD_WORDS = 2,
    parameter int RUN_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [RUN_W-1:0]       run_cycles,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [IMEM_DATA_W-1:0] load_data,
    input  logic                   load_last,
    output logic [IMEM_DATA_W-1:0] instruction_write,
    output logic [31:0]            write_address,
    output logic                   write_signal,
    output logic                   instruction_reset,
    output logic                   core_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W:0]        words_loaded
);
    localparam int PW = $clog2(PAD_WORDS + 2);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    boot_state_e state_q, state_d;
    logic load_ready_q, load_ready_d, write_signal_q, write_signal_d;
    logic instruction_reset_q, instruction_reset_d, core_reset_q, core_reset_d;
    logic busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [IMEM_DATA_W-1:0] instruction_write_q, instruction_write_d;
    logic [31:0] write_address_q, write_address_d;
    logic [ADDR_W:0] words_loaded_q, words_loaded_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0] pad_cnt_q, pad_cnt_d;
    logic accept, hs, pad_wr, pad_end, expire;

    // A word or pad slot is never consumed in the abort cycle
    assign accept  = start && !abort && state_q inside {S_IDLE, S_DONE, S_ERROR};
    assign hs      = load_valid && load_ready_q && !abort;
    assign pad_wr  = state_q == S_PAD && !abort;
    assign pad_end = pad_cnt_q == PW'(PAD_WORDS - 1) || addr_q == ADDR_MAX;

    boot_run_timer #(.RUN_W(RUN_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .budget (run_cycles),
        .en     (state_q == S_RUN),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: abort beats start; a last word at the top address leaves no room for padding
    always_comb begin
        state_d = state_q;
        if (abort) state_d = S_IDLE;
        else if (accept) state_d = S_CLEAR;
        else begin
            case (state_q)
                S_CLEAR: state_d = S_LOAD;
                S_LOAD:  if (hs) state_d = load_last ? ((PAD_WORDS == 0 || addr_q == ADDR_MAX) ? S_RUN : S_PAD)
                                                     : (addr_q == ADDR_MAX ? S_ERROR : S_LOAD);
                S_PAD:   if (pad_end) state_d = S_RUN;
                S_RUN:   if (expire) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are registered: status follows the next state, writes follow this cycle's handshake
    always_comb begin
        load_ready_d        = state_d == S_LOAD;
        instruction_reset_d = state_d == S_CLEAR;
        core_reset_d        = state_d != S_RUN;
        busy_d              = state_d inside {S_CLEAR, S_LOAD, S_PAD, S_RUN};
        done_d              = state_d == S_DONE;
        error_d             = state_d == S_ERROR;
        write_signal_d      = hs || pad_wr;
        instruction_write_d = hs ? load_data : pad_wr ? NOP_WORD : instruction_write_q;
        write_address_d     = write_signal_d ? 32'(addr_q) : write_address_q;
        addr_d              = accept ? '0 : write_signal_d ? addr_q + 1'b1 : addr_q;
        words_loaded_d      = accept ? '0 : hs ? words_loaded_q + 1'b1 : words_loaded_q;
        pad_cnt_d           = state_q == S_PAD ? pad_cnt_q + 1'b1 : '0;
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ready_q        <= 1'b0;
            instruction_reset_q <= 1'b0;
            core_reset_q        <= 1'b1;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            error_q             <= 1'b0;
            write_signal_q      <= 1'b0;
            instruction_write_q <= '0;
            write_address_q     <= '0;
            addr_q              <= '0;
            words_loaded_q      <= '0;
            pad_cnt_q           <= '0;
        end else begin
            load_ready_q        <= load_ready_d;
            instruction_reset_q <= instruction_reset_d;
            core_reset_q        <= core_reset_d;
            busy_q              <= busy_d;
            done_q              <= done_d;
            error_q             <= error_d;
            write_signal_q      <= write_signal_d;
            instruction_write_q <= instruction_write_d;
            write_address_q     <= write_address_d;
            addr_q              <= addr_d;
            words_loaded_q      <= words_loaded_d;
            pad_cnt_q           <= pad_cnt_d;
        end
    end

    assign load_ready        = load_ready_q;
    assign instruction_reset = instruction_reset_q;
    assign core_reset        = core_reset_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign write_signal      = write_signal_q;
    assign instruction_write = instruction_write_q;
    assign write_address     = write_address_q;
    assign words_loaded      = words_loaded_q;
endmodule
